// File: rtl/xcel_ctrl_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xcel_ctrl_regs_pkg
// Purpose  : Shared constants for the conv3D control/status register bank:
//            register byte offsets, CTRL/STATUS bit positions, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package xcel_ctrl_regs_pkg;

    // Register byte offsets inside the 64 B window
    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_IFM_ADDR  = 8'h08;
    localparam logic [7:0] REG_WT_ADDR   = 8'h0C;
    localparam logic [7:0] REG_OFM_ADDR  = 8'h10;
    localparam logic [7:0] REG_IFM_DIM   = 8'h14;
    localparam logic [7:0] REG_IFM_DEPTH = 8'h18;
    localparam logic [7:0] REG_OFM_DIM   = 8'h1C;
    localparam logic [7:0] REG_OFM_DEPTH = 8'h20;
    localparam logic [7:0] REG_CYCLES    = 8'h24;
    localparam logic [7:0] REG_RUNS      = 8'h28;

    // CTRL write bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;

    // STATUS read bits
    localparam int STAT_IDLE_BIT = 0;
    localparam int STAT_BUSY_BIT = 1;
    localparam int STAT_DONE_BIT = 2;
    localparam int STAT_ERR_BIT  = 3;

    // Run-control FSM
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/xcel_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : xcel_ctrl_regs_if
// Purpose  : CPU IO window plus accelerator handshake/config bundle for the
//            conv3D register bank. slave = register bank, master = its peers.
//            Optional macro XCEL_CTRL_IRQ_EN adds the irq signal.
// Revision : 1.0 - initial release
// ============================================================================
interface xcel_ctrl_regs_if #(
    parameter int OFFSET_W = 6
);
    logic                io_en;
    logic                io_we;
    logic [OFFSET_W-1:0] io_offset;
    logic [31:0]         io_wdata;
    logic [31:0]         io_rdata;
    logic                xcel_start;
    logic                xcel_done;
    logic                xcel_idle;
    logic [31:0]         ifm_ddr_addr;
    logic [31:0]         wt_ddr_addr;
    logic [31:0]         ofm_ddr_addr;
    logic [31:0]         ifm_dim;
    logic [31:0]         ifm_depth;
    logic [31:0]         ofm_dim;
    logic [31:0]         ofm_depth;
`ifdef XCEL_CTRL_IRQ_EN
    logic                irq;
`endif

    modport slave (
        input  io_en, io_we, io_offset, io_wdata, xcel_done, xcel_idle,
        output io_rdata, xcel_start,
               ifm_ddr_addr, wt_ddr_addr, ofm_ddr_addr,
               ifm_dim, ifm_depth, ofm_dim, ofm_depth
`ifdef XCEL_CTRL_IRQ_EN
        , output irq
`endif
    );

    modport master (
        output io_en, io_we, io_offset, io_wdata, xcel_done, xcel_idle,
        input  io_rdata, xcel_start,
               ifm_ddr_addr, wt_ddr_addr, ofm_ddr_addr,
               ifm_dim, ifm_depth, ofm_dim, ofm_depth
`ifdef XCEL_CTRL_IRQ_EN
        , input irq
`endif
    );

endinterface
`default_nettype wire

// File: rtl/xcel_ctrl_cfg_check.sv
`default_nettype none
// ============================================================================
// Module   : xcel_ctrl_cfg_check
// Purpose  : Combinational legality check of the layer dimensions against
//            the weight kernel edge (valid convolution, non-empty depths).
// Revision : 1.0 - initial release
// ============================================================================
module xcel_ctrl_cfg_check #(
    parameter int WT_DIM = 5
) (
    input  logic [31:0] ifm_dim_i,
    input  logic [31:0] ifm_depth_i,
    input  logic [31:0] ofm_dim_i,
    input  logic [31:0] ofm_depth_i,
    output logic        legal_o
);
    localparam logic [31:0] C_WT_DIM = 32'(WT_DIM);

    // Kernel must fit inside the input and the output edge must match a valid conv
    always_comb begin
        legal_o = (ifm_dim_i >= C_WT_DIM)
               && (ofm_dim_i == ifm_dim_i - C_WT_DIM + 32'd1)
               && (ifm_depth_i != 32'd0)
               && (ofm_depth_i != 32'd0);
    end

endmodule
`default_nettype wire

// File: rtl/xcel_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : xcel_ctrl_regs
// Purpose  : Memory-mapped control/status registers for the conv3D
//            accelerator: config capture, legality check, start pulse,
//            busy/done tracking and run-cycle / run counters.
//            Optional macro XCEL_CTRL_IRQ_EN adds irq = done & irq_enable.
// Revision : 1.0 - initial release
// ============================================================================
module xcel_ctrl_regs
    import xcel_ctrl_regs_pkg::*;
#(
    parameter int WT_DIM   = 5,
    parameter int OFFSET_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    xcel_ctrl_regs_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] ifm_addr_q, wt_addr_q, ofm_addr_q;
    logic [31:0] ifm_dim_q, ifm_depth_q, ofm_dim_q, ofm_depth_q;
    logic [31:0] cycles_q, runs_q, rdata_q;
    logic        done_q, cfg_err_q;

    logic [7:0]  w_off;
    logic        w_wr, w_rd, w_cfg_open, w_start_req, w_clear_req, w_busy;
    logic        w_legal, w_done_set, w_err_set, w_run_clear;
    logic [31:0] w_rd_val;
    logic        w_unused;

    // Word-aligned decode; the two byte-lane bits carry no meaning here
    assign w_off       = 8'({bus.io_offset[OFFSET_W-1:2], 2'b00});
    assign w_unused    = &{1'b0, bus.io_offset[1:0]};
    assign w_wr        = bus.io_en & bus.io_we;
    assign w_rd        = bus.io_en & ~bus.io_we;
    assign w_start_req = w_wr && (w_off == REG_CTRL) && bus.io_wdata[CTRL_START_BIT];
    assign w_clear_req = w_wr && (w_off == REG_CTRL) && bus.io_wdata[CTRL_CLEAR_BIT];
    assign w_cfg_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_busy      = (state_q == ST_CHECK) || (state_q == ST_START) || (state_q == ST_BUSY);

    xcel_ctrl_cfg_check #(.WT_DIM(WT_DIM)) u_cfg_check (
        .ifm_dim_i   (ifm_dim_q),
        .ifm_depth_i (ifm_depth_q),
        .ofm_dim_i   (ofm_dim_q),
        .ofm_depth_i (ofm_depth_q),
        .legal_o     (w_legal)
    );

    // Run-control state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Run-control next state and one-cycle status events
    always_comb begin
        state_d     = state_q;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        w_run_clear = 1'b0;
        case (state_q)
            ST_IDLE:  if (w_start_req) state_d = ST_CHECK;
            ST_CHECK: begin
                if (w_legal) begin
                    state_d = ST_START;
                end else begin
                    w_err_set = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.xcel_done) begin
                    w_done_set = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_start_req) begin
                    w_run_clear = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky done / cfg_err: set wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= w_done_set | (done_q    & ~(w_clear_req | w_run_clear));
            cfg_err_q <= w_err_set  | (cfg_err_q & ~(w_clear_req | w_run_clear));
        end
    end

    // Cycle counter (restarted by the start pulse, saturating) and run counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q <= '0;
            runs_q   <= '0;
        end else begin
            if (state_q == ST_START)
                cycles_q <= '0;
            else if ((state_q == ST_BUSY) && (cycles_q != 32'hFFFF_FFFF))
                cycles_q <= cycles_q + 32'd1;
            if (w_done_set)
                runs_q <= runs_q + 32'd1;
        end
    end

    // Config capture, frozen while a run is being launched or executing
    always_ff @(posedge clk) begin
        if (!rst) begin
            ifm_addr_q  <= '0;
            wt_addr_q   <= '0;
            ofm_addr_q  <= '0;
            ifm_dim_q   <= '0;
            ifm_depth_q <= '0;
            ofm_dim_q   <= '0;
            ofm_depth_q <= '0;
        end else if (w_wr && w_cfg_open) begin
            case (w_off)
                REG_IFM_ADDR:  ifm_addr_q  <= bus.io_wdata;
                REG_WT_ADDR:   wt_addr_q   <= bus.io_wdata;
                REG_OFM_ADDR:  ofm_addr_q  <= bus.io_wdata;
                REG_IFM_DIM:   ifm_dim_q   <= bus.io_wdata;
                REG_IFM_DEPTH: ifm_depth_q <= bus.io_wdata;
                REG_OFM_DIM:   ofm_dim_q   <= bus.io_wdata;
                REG_OFM_DEPTH: ofm_depth_q <= bus.io_wdata;
                default: ;
            endcase
        end
    end

`ifdef XCEL_CTRL_IRQ_EN
    logic irq_en_q;

    // Interrupt enable lives in CTRL and is writable in any state
    always_ff @(posedge clk) begin
        if (!rst)                              irq_en_q <= 1'b0;
        else if (w_wr && (w_off == REG_CTRL))  irq_en_q <= bus.io_wdata[CTRL_IRQEN_BIT];
    end

    assign bus.irq = done_q & irq_en_q;
`endif

    // Read-back multiplexer; unmapped words read as zero
    always_comb begin
        w_rd_val = '0;
        case (w_off)
`ifdef XCEL_CTRL_IRQ_EN
            REG_CTRL:      w_rd_val[CTRL_IRQEN_BIT] = irq_en_q;
`endif
            REG_STATUS: begin
                w_rd_val[STAT_IDLE_BIT] = bus.xcel_idle;
                w_rd_val[STAT_BUSY_BIT] = w_busy;
                w_rd_val[STAT_DONE_BIT] = done_q;
                w_rd_val[STAT_ERR_BIT]  = cfg_err_q;
            end
            REG_IFM_ADDR:  w_rd_val = ifm_addr_q;
            REG_WT_ADDR:   w_rd_val = wt_addr_q;
            REG_OFM_ADDR:  w_rd_val = ofm_addr_q;
            REG_IFM_DIM:   w_rd_val = ifm_dim_q;
            REG_IFM_DEPTH: w_rd_val = ifm_depth_q;
            REG_OFM_DIM:   w_rd_val = ofm_dim_q;
            REG_OFM_DEPTH: w_rd_val = ofm_depth_q;
            REG_CYCLES:    w_rd_val = cycles_q;
            REG_RUNS:      w_rd_val = runs_q;
            default: ;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (!rst)      rdata_q <= '0;
        else if (w_rd) rdata_q <= w_rd_val;
    end

    assign bus.io_rdata     = rdata_q;
    assign bus.xcel_start   = (state_q == ST_START);
    assign bus.ifm_ddr_addr = ifm_addr_q;
    assign bus.wt_ddr_addr  = wt_addr_q;
    assign bus.ofm_ddr_addr = ofm_addr_q;
    assign bus.ifm_dim      = ifm_dim_q;
    assign bus.ifm_depth    = ifm_depth_q;
    assign bus.ofm_dim      = ofm_dim_q;
    assign bus.ofm_depth    = ofm_depth_q;

endmodule
`default_nettype wire

// File: tb/tb_xcel_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_xcel_ctrl_regs
// Purpose  : Self-checking bench for xcel_ctrl_regs: directed scenarios with
//            literal expectations, then randomized traffic against a
//            behavioural register-bank model. Honours XCEL_CTRL_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xcel_ctrl_regs;
    localparam int WT = 5;
    localparam int P_IDLE = 0, P_CHECK = 1, P_START = 2, P_BUSY = 3, P_DONE = 4;
    localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_IFM_ADDR = 6'h08;
    localparam logic [5:0] A_IFM_DIM = 6'h14, A_IFM_DEPTH = 6'h18, A_OFM_DIM = 6'h1C;
    localparam logic [5:0] A_OFM_DEPTH = 6'h20, A_CYCLES = 6'h24, A_RUNS = 6'h28;
`ifdef XCEL_CTRL_IRQ_EN
    localparam logic [31:0] GO = 32'h5;  // start + irq_enable
`else
    localparam logic [31:0] GO = 32'h1;
`endif

    logic clk;
    logic rst;
    xcel_ctrl_regs_if #(.OFFSET_W(6)) bus ();

    xcel_ctrl_regs #(.WT_DIM(WT), .OFFSET_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_ph;
    logic [31:0] m_cfg [7];     // ifm_addr, wt_addr, ofm_addr, ifm_dim, ifm_depth, ofm_dim, ofm_depth
    logic [31:0] m_cycles, m_runs, m_rdata;
    bit          m_done, m_err, m_irqen;
    bit          model_valid = 1'b0;

    function automatic logic [31:0] model_read(int w);
        logic [31:0] v;
        v = 32'h0;
        if (w == 0) begin
`ifdef XCEL_CTRL_IRQ_EN
            v = {29'h0, m_irqen, 2'b00};
`endif
        end else if (w == 1) begin
            v = {28'h0, m_err, m_done, (m_ph == P_CHECK || m_ph == P_START || m_ph == P_BUSY), bus.xcel_idle};
        end else if (w >= 2 && w <= 8) begin
            v = m_cfg[w-2];
        end else if (w == 9) begin
            v = m_cycles;
        end else if (w == 10) begin
            v = m_runs;
        end
        return v;
    endfunction

    task automatic model_step();
        int w;
        bit wr, st, cl, legal, open;
        if (!rst) begin
            m_ph = P_IDLE; m_cycles = 0; m_runs = 0; m_rdata = 0;
            m_done = 0; m_err = 0; m_irqen = 0;
            for (int i = 0; i < 7; i++) m_cfg[i] = 0;
            return;
        end
        w  = int'(bus.io_offset[5:2]);
        wr = bus.io_en && bus.io_we;
        if (bus.io_en && !bus.io_we) m_rdata = model_read(w);
        st   = wr && (w == 0) && bus.io_wdata[0];
        cl   = wr && (w == 0) && bus.io_wdata[1];
        open = (m_ph == P_IDLE) || (m_ph == P_DONE);
        if (wr && w == 0) m_irqen = bus.io_wdata[2];
        if (wr && open && w >= 2 && w <= 8) m_cfg[w-2] = bus.io_wdata;
        if (cl) begin m_done = 0; m_err = 0; end
        legal = (longint'(m_cfg[3]) >= WT) && (longint'(m_cfg[5]) + WT - 1 == longint'(m_cfg[3]))
             && (m_cfg[4] != 0) && (m_cfg[6] != 0);
        case (m_ph)
            P_IDLE:  if (st) m_ph = P_CHECK;
            P_DONE:  if (st) begin m_done = 0; m_err = 0; m_ph = P_CHECK; end
            P_CHECK: if (legal) m_ph = P_START; else begin m_err = 1; m_ph = P_IDLE; end
            P_START: begin m_cycles = 0; m_ph = P_BUSY; end
            P_BUSY: begin
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
                if (bus.xcel_done) begin m_done = 1; m_runs = m_runs + 1; m_ph = P_DONE; end
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    // ---------------- literal pins (handed to the compare process) ----------------
    int          pin_seq = 0;
    int          pin_id  = 0;
    logic [31:0] pin_exp = 0;
    string       pin_name = "";

    task automatic pin(int id, string nm, logic [31:0] e);
        pin_id = id; pin_name = nm; pin_exp = e; pin_seq++;
    endtask

    function automatic logic [31:0] pin_val(int id);
        case (id)
            0: return bus.io_rdata;
            1: return {31'h0, bus.xcel_start};
            2: return bus.ifm_ddr_addr;
            3: return bus.ifm_dim;
`ifdef XCEL_CTRL_IRQ_EN
            4: return {31'h0, bus.irq};
`endif
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    int n_cmp, n_fail, pin_seen;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; pin_seen = 0;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("io_rdata",     bus.io_rdata,     m_rdata);
                chk("xcel_start",   {31'h0, bus.xcel_start}, {31'h0, (m_ph == P_START)});
                chk("ifm_ddr_addr", bus.ifm_ddr_addr, m_cfg[0]);
                chk("wt_ddr_addr",  bus.wt_ddr_addr,  m_cfg[1]);
                chk("ofm_ddr_addr", bus.ofm_ddr_addr, m_cfg[2]);
                chk("ifm_dim",      bus.ifm_dim,      m_cfg[3]);
                chk("ifm_depth",    bus.ifm_depth,    m_cfg[4]);
                chk("ofm_dim",      bus.ofm_dim,      m_cfg[5]);
                chk("ofm_depth",    bus.ofm_depth,    m_cfg[6]);
`ifdef XCEL_CTRL_IRQ_EN
                chk("irq",          {31'h0, bus.irq}, {31'h0, (m_done && m_irqen)});
`endif
            end
            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                chk(pin_name, pin_val(pin_id), pin_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.xcel_done = 1'b0;
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d);
        bus.io_en = 1'b1; bus.io_we = 1'b1; bus.io_offset = a; bus.io_wdata = d;
        tick();
    endtask

    task automatic rd(logic [5:0] a);
        bus.io_en = 1'b1; bus.io_we = 1'b0; bus.io_offset = a;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        bus.io_en = 0; bus.io_we = 0; bus.io_offset = 0; bus.io_wdata = 0;
        bus.xcel_done = 0; bus.xcel_idle = 1;
        tick(); model_valid = 1'b1;
        tick(); rst = 1'b1;
        pin(0, "reset_rdata", 32'h0);
        tick();

        // Legal layer and launch
        wr(A_IFM_DIM, 32); pin(3, "ifm_dim_written", 32);
        wr(A_IFM_DEPTH, 1); wr(A_OFM_DIM, 28); wr(A_OFM_DEPTH, 6);
        wr(A_CTRL, GO);   pin(1, "start_not_yet", 0);
        tick();           pin(1, "start_pulse", 1);
        bus.xcel_idle = 1'b0;
        rd(A_STATUS);     pin(0, "status_busy", 32'h2);
        for (int i = 0; i < 99; i++) tick();
        bus.xcel_done = 1'b1; bus.xcel_idle = 1'b1;
        tick();
`ifdef XCEL_CTRL_IRQ_EN
        pin(4, "irq_on_done", 1);
`endif
        rd(A_STATUS);     pin(0, "status_done_idle", 32'h5);
        rd(A_CYCLES);     pin(0, "cycles_100", 32'd100);
        rd(A_RUNS);       pin(0, "runs_1", 32'd1);

        // Illegal output edge
        wr(A_OFM_DIM, 27);
        wr(A_CTRL, 32'h1);
        tick();           pin(1, "no_start_on_err", 0);
        rd(A_STATUS);     pin(0, "status_cfg_err", 32'h9);

        // Config frozen while busy, second start ignored, clear vs done
        wr(A_OFM_DIM, 28);
        wr(A_IFM_ADDR, 32'h1111_0000); pin(2, "ifm_addr_idle", 32'h1111_0000);
        wr(A_CTRL, 32'h1);
        tick(); bus.xcel_idle = 1'b0;
        tick();
        wr(A_IFM_ADDR, 32'hDEAD_0000); pin(2, "ifm_addr_frozen", 32'h1111_0000);
        wr(A_CTRL, 32'h1);
        tick(); tick(); tick();
        bus.io_en = 1; bus.io_we = 1; bus.io_offset = A_CTRL; bus.io_wdata = 32'h2;
        bus.xcel_done = 1; bus.xcel_idle = 1;
        tick();
        rd(A_STATUS);     pin(0, "status_set_wins", 32'h5);
        wr(A_IFM_ADDR, 32'hDEAD_0000); pin(2, "ifm_addr_after_done", 32'hDEAD_0000);
        rd(A_RUNS);       pin(0, "runs_2", 32'd2);

        // Reset in the middle of a run
        wr(A_CTRL, GO);
        tick(); bus.xcel_idle = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0; tick(); rst = 1'b1;
        pin(3, "ifm_dim_after_rst", 32'h0);
`ifdef XCEL_CTRL_IRQ_EN
        tick(); pin(4, "irq_after_rst", 0);
`endif
        rd(A_RUNS);       pin(0, "runs_after_rst", 32'h0);
        rd(A_STATUS);     pin(0, "status_after_rst", 32'h0);
        bus.xcel_idle = 1'b1;
        rd(A_CYCLES);     pin(0, "cycles_after_rst", 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int w;
            rst           = ($urandom_range(0, 599) != 0);
            bus.xcel_idle = $urandom_range(0, 1) != 0;
            bus.xcel_done = ($urandom_range(0, 11) == 0);
            bus.io_en     = ($urandom_range(0, 9) < 6);
            bus.io_we     = $urandom_range(0, 1) != 0;
            w             = int'($urandom_range(0, 15));
            bus.io_offset = 6'(w * 4 + int'($urandom_range(0, 3)));
            case (w)
                0:       bus.io_wdata = {29'h0, 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
                5:       bus.io_wdata = $urandom_range(0, 12);
                7:       bus.io_wdata = ($urandom_range(0, 3) != 0) ? m_cfg[3] - 32'd4 : $urandom_range(0, 10);
                6, 8:    bus.io_wdata = $urandom_range(0, 3);
                default: bus.io_wdata = $urandom;
            endcase
            @(posedge clk);
            model_step();
            #1;
        end
        rst = 1'b1; bus.io_en = 0; bus.xcel_done = 0;
        tick(); tick();
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
